// File: rtl/split_data_mem.sv
// Byte-lane data RAM with registered responses behind a valid/ready request port.
// Word-crossing accesses take two memory cycles (IDLE then SECOND) or are rejected.
module split_data_mem #(
  parameter int ADDR_BIT = 12,
  parameter int LANES = 4,
  parameter bit ALLOW_MISALIGN = 1'b1,
  localparam int DATA_W = 8 * LANES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_BIT-1:0] req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  input  logic [ADDR_BIT-1:0] addr_dbg,
  output logic [DATA_W-1:0]   data_dbg
);
  localparam int OFF_W  = $clog2(LANES);
  localparam int WORD_W = ADDR_BIT - OFF_W;
  localparam int DEPTH  = 1 << WORD_W;
  localparam int CW     = 5;
  localparam logic [CW-1:0] LANES_C = CW'(LANES);

  typedef enum logic {S_IDLE, S_SECOND} state_t;

  state_t r_state, w_state_nxt;
  logic [7:0] r_bank [LANES][DEPTH];

  logic              r_resp_valid, r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;

  logic [WORD_W-1:0] r_word2;
  logic [CW-1:0]     r_off, r_n;
  logic              r_we, r_signed;
  logic [DATA_W-1:0] r_wdata, r_lo;

  logic [OFF_W-1:0]  w_req_off;
  logic [WORD_W-1:0] w_req_word;
  logic [CW-1:0]     w_req_n, w_req_end;
  logic              w_illegal, w_split, w_fire, w_second, w_do_write;

  logic [WORD_W-1:0] w_cur_word;
  logic [CW-1:0]     w_cur_off, w_cur_n;
  logic [DATA_W-1:0] w_cur_wdata;
  logic              w_cur_signed;

  logic [7:0]        w_rd_row [LANES];
  logic [LANES-1:0]  w_lane_we;
  logic [7:0]        w_lane_wdata [LANES];
  logic [DATA_W-1:0] w_gather, w_ext;
  logic              w_sign;
  logic [CW-1:0]     w_lpos, w_bpos;

  assign w_req_off  = req_addr[OFF_W-1:0];
  assign w_req_word = req_addr[ADDR_BIT-1:OFF_W];
  assign w_req_n    = CW'(1) << req_size;
  assign w_req_end  = CW'(w_req_off) + w_req_n;
  assign w_illegal  = (w_req_n > LANES_C) || (!ALLOW_MISALIGN && (w_req_end > LANES_C));
  assign w_split    = !w_illegal && (w_req_end > LANES_C);
  assign w_fire     = req_valid && req_ready && !rst;
  assign w_second   = (r_state == S_SECOND);

  // In SECOND the saved request drives the lane logic against word w+1.
  assign w_cur_word   = w_second ? r_word2   : w_req_word;
  assign w_cur_off    = w_second ? r_off     : CW'(w_req_off);
  assign w_cur_n      = w_second ? r_n       : w_req_n;
  assign w_cur_wdata  = w_second ? r_wdata   : req_wdata;
  assign w_cur_signed = w_second ? r_signed  : req_signed;
  assign w_do_write   = w_second ? (r_we && !rst) : (w_fire && req_we && !w_illegal);

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_rd_row[l] = r_bank[l][w_cur_word];
    end
  end

  always_comb begin
    w_lane_we = '0;
    w_lpos    = '0;
    for (int l = 0; l < LANES; l++) begin
      w_lane_wdata[l] = 8'h00;
      w_lpos = w_second ? CW'(l + LANES) : CW'(l);
      if (w_do_write && (w_lpos >= w_cur_off) && ((w_lpos - w_cur_off) < w_cur_n)) begin
        w_lane_we[l]    = 1'b1;
        w_lane_wdata[l] = w_cur_wdata[8*int'(w_lpos - w_cur_off) +: 8];
      end
    end
  end

  // Byte b of the result lives at lane (off+b) mod LANES; the first cycle takes
  // the bytes still inside word w, the second cycle the ones that spilled over.
  always_comb begin
    w_gather = w_second ? r_lo : '0;
    w_bpos   = '0;
    w_sign   = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      w_bpos = w_cur_off + CW'(l);
      if (CW'(l) < w_cur_n) begin
        if (!w_second && (w_bpos < LANES_C)) begin
          w_gather[8*l +: 8] = w_rd_row[w_bpos[OFF_W-1:0]];
        end else if (w_second && (w_bpos >= LANES_C)) begin
          w_gather[8*l +: 8] = w_rd_row[w_bpos[OFF_W-1:0]];
        end
      end
    end
    for (int l = 0; l < LANES; l++) begin
      if (w_cur_n == CW'(l + 1)) w_sign = w_gather[8*l + 7];
    end
    w_ext = w_gather;
    for (int l = 0; l < LANES; l++) begin
      if (CW'(l) >= w_cur_n) w_ext[8*l +: 8] = {8{w_cur_signed & w_sign}};
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (w_lane_we[l]) r_bank[l][w_cur_word] <= w_lane_wdata[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && w_split) w_state_nxt = S_SECOND;
      end
      S_SECOND: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_fire && w_split) begin
      r_word2  <= w_req_word + WORD_W'(1);
      r_off    <= CW'(w_req_off);
      r_n      <= w_req_n;
      r_we     <= req_we;
      r_signed <= req_signed;
      r_wdata  <= req_wdata;
      r_lo     <= w_gather;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      if (w_second) begin
        r_resp_valid <= 1'b1;
        r_resp_rdata <= r_we ? '0 : w_ext;
      end else if (w_fire) begin
        if (w_illegal) begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
        end else if (!w_split) begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= req_we ? '0 : w_ext;
        end
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

  always_comb begin
    data_dbg = '0;
    for (int l = 0; l < LANES; l++) begin
      data_dbg[8*l +: 8] = r_bank[l][addr_dbg[ADDR_BIT-1:OFF_W]];
    end
  end

endmodule

// File: tb/tb_split_data_mem.sv
// Bench for split_data_mem: one instance with misaligned splitting, one that rejects it.
// Expected responses are queued at drive time and matched by per-instance monitors.
module tb_split_data_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_a, req_valid_b, req_ready_a, req_ready_b;
  logic        req_we, req_signed;
  logic [1:0]  req_size;
  logic [11:0] req_addr, addr_dbg_a, addr_dbg_b;
  logic [31:0] req_wdata;
  logic        resp_valid_a, resp_valid_b, resp_err_a, resp_err_b;
  logic [31:0] resp_rdata_a, resp_rdata_b, data_dbg_a, data_dbg_b;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    string       name;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  split_data_mem #(.ADDR_BIT(12), .LANES(4), .ALLOW_MISALIGN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_a),
    .resp_rdata(resp_rdata_a), .resp_err(resp_err_a), .addr_dbg(addr_dbg_a),
    .data_dbg(data_dbg_a)
  );

  split_data_mem #(.ADDR_BIT(12), .LANES(4), .ALLOW_MISALIGN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_b),
    .resp_rdata(resp_rdata_b), .resp_err(resp_err_b), .addr_dbg(addr_dbg_b),
    .data_dbg(data_dbg_b)
  );

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (resp_valid_a) begin
      n_tests++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp_a: got rdata=%h err=%b at cycle %0d, required no response", resp_rdata_a, resp_err_a, cyc);
      end else begin
        e = q_a.pop_front();
        if (resp_rdata_a !== e.rdata || resp_err_a !== e.err || cyc != e.due) begin
          n_fail++;
          $display("FAIL %s: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d", e.name, resp_rdata_a, resp_err_a, cyc, e.rdata, e.err, e.due);
        end
      end
    end else if (q_a.size() != 0 && q_a[0].due < cyc) begin
      n_tests++;
      n_fail++;
      e = q_a.pop_front();
      $display("FAIL %s_missing: got no response by cycle %0d, required one at cycle %0d", e.name, cyc, e.due);
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (resp_valid_b) begin
      n_tests++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp_b: got rdata=%h err=%b at cycle %0d, required no response", resp_rdata_b, resp_err_b, cyc);
      end else begin
        e = q_b.pop_front();
        if (resp_rdata_b !== e.rdata || resp_err_b !== e.err || cyc != e.due) begin
          n_fail++;
          $display("FAIL %s: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d", e.name, resp_rdata_b, resp_err_b, cyc, e.rdata, e.err, e.due);
        end
      end
    end else if (q_b.size() != 0 && q_b[0].due < cyc) begin
      n_tests++;
      n_fail++;
      e = q_b.pop_front();
      $display("FAIL %s_missing: got no response by cycle %0d, required one at cycle %0d", e.name, cyc, e.due);
    end
  end

  task automatic send(input bit b, input logic we, input logic [1:0] size, input logic sgn,
                      input logic [11:0] addr, input logic [31:0] wdata,
                      input logic [31:0] er, input logic ee, input bit split,
                      input bit want_resp, input string name);
    exp_t e;
    int waited = 0;
    @(negedge clk);
    while (!(b ? req_ready_b : req_ready_a) && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (!(b ? req_ready_b : req_ready_a)) begin
      n_fail++;
      $display("FAIL %s_ready: req_ready=0 after %0d cycles, required 1", name, waited);
    end
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    if (want_resp) begin
      e.rdata = er; e.err = ee; e.due = cyc + (split ? 2 : 1); e.name = name;
      if (b) q_b.push_back(e);
      else   q_a.push_back(e);
    end
    if (b) req_valid_b = 1'b1;
    else   req_valid_a = 1'b1;
    @(posedge clk);
    #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && i < 10) begin
      @(negedge clk);
      #1;
      i++;
    end
    n_tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d responses outstanding, required 0/0", q_a.size(), q_b.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (req_ready_a !== 1'b1 || resp_valid_a !== 1'b0 || resp_err_a !== 1'b0 || resp_rdata_a !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_a: ready=%b valid=%b err=%b rdata=%h, required 1 0 0 00000000", req_ready_a, resp_valid_a, resp_err_a, resp_rdata_a);
    end
    n_tests++;
    if (req_ready_b !== 1'b1 || resp_valid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: ready=%b valid=%b, required 1 0", req_ready_b, resp_valid_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_ignore();
    send(0, 1, 2'd2, 0, 12'h040, 32'h0000_0000, 32'h0, 0, 0, 1, "clear_40");
    drain();
    @(negedge clk);
    rst = 1'b1;
    req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_addr = 12'h040; req_wdata = 32'h5555_5555;
    req_valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_valid_a = 1'b0;
    addr_dbg_a = 12'h040;
    #1;
    n_tests++;
    if (data_dbg_a !== 32'h0) begin
      n_fail++;
      $display("FAIL store_during_reset: dbg(0x040)=%h, required 00000000", data_dbg_a);
    end
  endtask

  task automatic test_aligned();
    send(0, 1, 2'd2, 0, 12'h010, 32'hDEAD_BEEF, 32'h0, 0, 0, 1, "store_w_10");
    send(0, 0, 2'd2, 0, 12'h010, 32'h0, 32'hDEAD_BEEF, 0, 0, 1, "load_w_10");
    drain();
    addr_dbg_a = 12'h012;
    #1;
    n_tests++;
    if (data_dbg_a !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL dbg_10: dbg=%h, required deadbeef", data_dbg_a);
    end
  endtask

  task automatic test_extension();
    send(0, 1, 2'd2, 0, 12'h020, 32'h80FF_7F01, 32'h0, 0, 0, 1, "store_w_20");
    send(0, 0, 2'd0, 1, 12'h023, 32'h0, 32'hFFFF_FF80, 0, 0, 1, "lb_s_23");
    send(0, 0, 2'd0, 0, 12'h023, 32'h0, 32'h0000_0080, 0, 0, 1, "lb_u_23");
    send(0, 0, 2'd1, 1, 12'h022, 32'h0, 32'hFFFF_80FF, 0, 0, 1, "lh_s_22");
    send(0, 0, 2'd1, 0, 12'h020, 32'h0, 32'h0000_7F01, 0, 0, 1, "lh_u_20");
    send(0, 0, 2'd1, 1, 12'h020, 32'h0, 32'h0000_7F01, 0, 0, 1, "lh_s_20");
    send(0, 0, 2'd0, 1, 12'h021, 32'h0, 32'h0000_007F, 0, 0, 1, "lb_s_21");
    drain();
  endtask

  task automatic test_back_to_back();
    send(0, 1, 2'd0, 0, 12'h021, 32'h0000_00A5, 32'h0, 0, 0, 1, "sb_21");
    send(0, 0, 2'd0, 0, 12'h021, 32'h0, 32'h0000_00A5, 0, 0, 1, "lb_u_21_after_store");
    send(0, 1, 2'd1, 0, 12'h012, 32'h0000_1234, 32'h0, 0, 0, 1, "sh_12");
    send(0, 0, 2'd2, 0, 12'h010, 32'h0, 32'h1234_BEEF, 0, 0, 1, "lw_10_after_sh");
    send(0, 0, 2'd2, 1, 12'h020, 32'h0, 32'h80FF_A501, 0, 0, 1, "lw_20_after_sb");
    drain();
  endtask

  task automatic test_split();
    send(0, 1, 2'd2, 0, 12'h000, 32'h4433_2211, 32'h0, 0, 0, 1, "store_w_00");
    send(0, 1, 2'd2, 0, 12'h004, 32'h8877_6655, 32'h0, 0, 0, 1, "store_w_04");
    send(0, 0, 2'd2, 0, 12'h003, 32'h0, 32'h7766_5544, 0, 1, 1, "split_lw_03");
    @(negedge clk);
    n_tests++;
    if (req_ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL split_ready_low: req_ready=%b, required 0", req_ready_a);
    end
    @(negedge clk);
    n_tests++;
    if (req_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL split_ready_back: req_ready=%b, required 1", req_ready_a);
    end
    send(0, 1, 2'd2, 0, 12'h006, 32'hAABB_CCDD, 32'h0, 0, 1, 1, "split_sw_06");
    send(0, 0, 2'd2, 0, 12'h004, 32'h0, 32'hCCDD_6655, 0, 0, 1, "lw_04_after_split");
    send(0, 0, 2'd1, 0, 12'h008, 32'h0, 32'h0000_AABB, 0, 0, 1, "lh_u_08_after_split");
    send(0, 0, 2'd1, 1, 12'h007, 32'h0, 32'hFFFF_BBCC, 0, 1, 1, "split_lh_s_07");
    drain();
  endtask

  task automatic test_top_wrap();
    send(0, 1, 2'd1, 0, 12'hFFF, 32'h0000_1234, 32'h0, 0, 1, 1, "split_sh_fff");
    send(0, 0, 2'd1, 0, 12'hFFF, 32'h0, 32'h0000_1234, 0, 1, 1, "split_lh_fff");
    drain();
    addr_dbg_a = 12'hFFC;
    #1;
    n_tests++;
    if (data_dbg_a[31:24] !== 8'h34) begin
      n_fail++;
      $display("FAIL wrap_byte_fff: byte=%h, required 34", data_dbg_a[31:24]);
    end
    addr_dbg_a = 12'h000;
    #1;
    n_tests++;
    if (data_dbg_a[7:0] !== 8'h12) begin
      n_fail++;
      $display("FAIL wrap_byte_000: byte=%h, required 12", data_dbg_a[7:0]);
    end
  endtask

  task automatic test_illegal();
    send(1, 1, 2'd2, 0, 12'h000, 32'h0102_0304, 32'h0, 0, 0, 1, "b_store_w_00");
    send(1, 1, 2'd2, 0, 12'h004, 32'h0506_0708, 32'h0, 0, 0, 1, "b_store_w_04");
    send(1, 1, 2'd2, 0, 12'h002, 32'hFFFF_FFFF, 32'h0, 1, 0, 1, "b_misaligned_sw_02");
    send(1, 0, 2'd2, 0, 12'h001, 32'h0, 32'h0, 1, 0, 1, "b_misaligned_lw_01");
    send(1, 0, 2'd3, 0, 12'h000, 32'h0, 32'h0, 1, 0, 1, "b_dword_load");
    send(1, 0, 2'd1, 0, 12'h002, 32'h0, 32'h0000_0102, 0, 0, 1, "b_lh_u_02");
    send(0, 1, 2'd3, 0, 12'h020, 32'hFFFF_FFFF, 32'h0, 1, 0, 1, "a_dword_store");
    drain();
    addr_dbg_b = 12'h000;
    #1;
    n_tests++;
    if (data_dbg_b !== 32'h0102_0304) begin
      n_fail++;
      $display("FAIL b_dbg_00_unchanged: dbg=%h, required 01020304", data_dbg_b);
    end
    addr_dbg_b = 12'h004;
    #1;
    n_tests++;
    if (data_dbg_b !== 32'h0506_0708) begin
      n_fail++;
      $display("FAIL b_dbg_04_unchanged: dbg=%h, required 05060708", data_dbg_b);
    end
    addr_dbg_a = 12'h020;
    #1;
    n_tests++;
    if (data_dbg_a !== 32'h80FF_A501) begin
      n_fail++;
      $display("FAIL a_dbg_20_unchanged: dbg=%h, required 80ffa501", data_dbg_a);
    end
  endtask

  task automatic test_reset_mid_split();
    send(0, 1, 2'd2, 0, 12'h004, 32'h1111_1111, 32'h0, 0, 0, 1, "store_w_04_ones");
    send(0, 1, 2'd2, 0, 12'h008, 32'h2222_2222, 32'h0, 0, 0, 1, "store_w_08_twos");
    drain();
    send(0, 1, 2'd2, 0, 12'h006, 32'hAABB_CCDD, 32'h0, 0, 1, 0, "split_sw_06_reset");
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (req_ready_a !== 1'b1 || resp_valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_split_state: ready=%b valid=%b, required 1 0", req_ready_a, resp_valid_a);
    end
    repeat (2) @(negedge clk);
    addr_dbg_a = 12'h004;
    #1;
    n_tests++;
    if (data_dbg_a !== 32'hCCDD_1111) begin
      n_fail++;
      $display("FAIL reset_mid_split_first: dbg(0x004)=%h, required ccdd1111", data_dbg_a);
    end
    addr_dbg_a = 12'h008;
    #1;
    n_tests++;
    if (data_dbg_a !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL reset_mid_split_second: dbg(0x008)=%h, required 22222222", data_dbg_a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    addr_dbg_a = '0; addr_dbg_b = '0;
    test_reset();
    test_reset_ignore();
    test_aligned();
    test_extension();
    test_back_to_back();
    test_split();
    test_top_wrap();
    test_illegal();
    test_reset_mid_split();
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
